// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO. It turns the FIFO's one-cycle read latency
// into a registered valid/ready stream, using a 2-entry skid buffer.
module fifo_stream_reader #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  underflow_err
);

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic [FIFO_WIDTH-1:0] head_q, head_d;
    logic [FIFO_WIDTH-1:0] tail_q, tail_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  uerr_q, uerr_d;

    logic       pop;
    logic       capture;
    logic [2:0] pending;

    assign pop     = (occ_q != 2'd0) & m_ready;
    assign capture = inflight_q;
    assign pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

    // Reset gates the request directly so no read is issued while the buffer is held clear.
    assign fifo_rd_en = rst_n & en & ~fifo_empty & (pending < 3'd2);

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({capture, pop})
            2'b10: begin
                occ_d = occ_q + 2'd1;
                if (occ_q == 2'd0) begin
                    head_d = fifo_data_out;
                end else begin
                    tail_d = fifo_data_out;
                end
            end
            2'b01: begin
                occ_d  = occ_q - 2'd1;
                head_d = tail_q;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = fifo_data_out;
                end else begin
                    head_d = tail_q;
                    tail_d = fifo_data_out;
                end
            end
            default: ;
        endcase
        cnt_d  = cnt_q + CNT_WIDTH'(pop);
        uerr_d = uerr_q | fifo_underflow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            uerr_q     <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_rd_en;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            uerr_q     <= uerr_d;
        end
    end

    assign m_valid       = (occ_q != 2'd0);
    assign m_data        = head_q;
    assign rd_count      = cnt_q;
    assign underflow_err = uerr_q;

    // The issue rule keeps occ + inflight <= 2, so a capture without a pop never meets a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(capture && !pop && occ_q == 2'd2));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader. It uses a behavioural FIFO with one cycle of read latency,
// and the DUT counter is 4 bits wide so that the counter wrap can be reached.
module tb_fifo_stream_reader;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        fifo_rd_en;
    logic [15:0] fifo_dout = '0;
    logic        fifo_empty;
    logic        uf_force;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_ready;
    logic [3:0]  rd_count;
    logic        underflow_err;

    logic [15:0] mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    int n_checks = 0;
    int n_err    = 0;

    fifo_stream_reader #(.FIFO_WIDTH(16), .CNT_WIDTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_data_out  (fifo_dout),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (uf_force),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_ready        (m_ready),
        .rd_count       (rd_count),
        .underflow_err  (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] v);
        mem[wr_ptr] = v;
        wr_ptr++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        rst_n    = 1'b0;
        en       = 1'b0;
        m_ready  = 1'b0;
        uf_force = 1'b0;
        next_cycle();
        next_cycle();
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_data", 32'(m_data), 0);
        chk("rst_count", 32'(rd_count), 0);
        chk("rst_uerr", 32'(underflow_err), 0);
        rst_n = 1'b1;
        next_cycle();

        // Latency and streaming.
        push(16'hA001); push(16'hA002); push(16'hA003);
        en = 1'b1; m_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("lat_rd_en", 32'(fifo_rd_en), (c <= 3) ? 1 : 0);
            chk("lat_valid", 32'(m_valid), (c >= 3 && c <= 5) ? 1 : 0);
            if (c >= 3 && c <= 5) chk("lat_data", 32'(m_data), 32'h0000A000 + c - 2);
            next_cycle();
        end
        en = 1'b0; m_ready = 1'b0;
        chk("lat_count", 32'(rd_count), 3);

        // Backpressure, then release.
        push(16'hB001); push(16'hB002); push(16'hB003); push(16'hB004); push(16'hB005);
        en = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            if (c == 7) m_ready = 1'b1;
            @(negedge clk);
            chk("bp_rd_en", 32'(fifo_rd_en), (c <= 2 || (c >= 7 && c <= 9)) ? 1 : 0);
            chk("bp_valid", 32'(m_valid), (c >= 3 && c <= 11) ? 1 : 0);
            if (c >= 3 && c <= 11)
                chk("bp_data", 32'(m_data), (c < 7) ? 32'h0000B001 : 32'h0000B000 + c - 6);
            next_cycle();
        end
        chk("bp_count", 32'(rd_count), 8);

        // Empty FIFO with enable and ready high.
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk("empty_rd_en", 32'(fifo_rd_en), 0);
            chk("empty_valid", 32'(m_valid), 0);
            chk("empty_uerr", 32'(underflow_err), 0);
            next_cycle();
        end
        chk("empty_count", 32'(rd_count), 8);

        // Drop enable after two reads have been issued.
        push(16'hC001); push(16'hC002); push(16'hC003); push(16'hC004);
        for (int c = 1; c <= 6; c++) begin
            if (c == 3) en = 1'b0;
            @(negedge clk);
            chk("dis_rd_en", 32'(fifo_rd_en), (c <= 2) ? 1 : 0);
            chk("dis_valid", 32'(m_valid), (c == 3 || c == 4) ? 1 : 0);
            if (c == 3 || c == 4) chk("dis_data", 32'(m_data), 32'h0000C000 + c - 2);
            next_cycle();
        end
        chk("dis_count", 32'(rd_count), 10);

        // One-cycle underflow pulse sets the sticky error.
        uf_force = 1'b1;
        next_cycle();
        uf_force = 1'b0;
        chk("uerr_set", 32'(underflow_err), 1);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            chk("uerr_hold", 32'(underflow_err), 1);
        end

        // Reset mid-stream with one word buffered and one in flight.
        m_ready = 1'b0;
        push(16'hD001); push(16'hD002); push(16'hD003);
        en = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk("pre_rst_rd_en", 32'(fifo_rd_en), 1);
            next_cycle();
        end
        chk("pre_rst_valid", 32'(m_valid), 1);
        chk("pre_rst_data", 32'(m_data), 32'h0000C003);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_en", 32'(fifo_rd_en), 0);
        chk("mid_rst_valid", 32'(m_valid), 0);
        chk("mid_rst_data", 32'(m_data), 0);
        chk("mid_rst_count", 32'(rd_count), 0);
        chk("mid_rst_uerr", 32'(underflow_err), 0);
        next_cycle();
        next_cycle();
        m_ready = 1'b1;
        rst_n   = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("post_rst_rd_en", 32'(fifo_rd_en), (c <= 3) ? 1 : 0);
            chk("post_rst_valid", 32'(m_valid), (c >= 3 && c <= 5) ? 1 : 0);
            if (c >= 3 && c <= 5) chk("post_rst_data", 32'(m_data), 32'h0000D000 + c - 2);
            next_cycle();
        end
        chk("post_rst_count", 32'(rd_count), 3);

        // 14 more words bring the count to 17, which wraps the 4-bit counter to 1.
        for (int i = 1; i <= 14; i++) push(16'(32'h0000E000 + i));
        k = 0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                k++;
                chk("wrap_data", 32'(m_data), 32'h0000E000 + k);
            end
            next_cycle();
        end
        chk("wrap_words", k, 14);
        chk("wrap_count", 32'(rd_count), 1);
        chk("wrap_valid", 32'(m_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
